ptr_alloc_mgr: RTL and testbench

- Consumer and returner of buffer pointers for the free-queue FIFO.
- Pops free pointers from the free queue to serve frame-write allocation requests, and records a per-pointer reference count (one per destination port).
- Decrements that count on each per-port release, and pushes the pointer back into the free queue when the count reaches zero.
- Sits between the switch-core write/read ports and the free queue.

---
 rtl/ptr_alloc_mgr.sv | 134 +++++++++++++
 tb/tb_ptr_alloc_mgr.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptr_alloc_mgr.sv
`default_nettype none
// ============================================================================
// Module  : ptr_alloc_mgr
// Brief   : Allocates free-queue pointers with per-pointer reference counts,
//           returns a pointer to the free queue when its count drops to zero.
//           Optional macro PTR_ALLOC_STAT_EN builds the allocation stall counter.
// Revision: 1.0
// ============================================================================
module ptr_alloc_mgr #(
   parameter int PTR_W = 10,
   parameter int DEPTH = 512,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PTR_W-1:0] fq_ptr_din,
   input  logic             fq_empty,
   input  logic             fq_act,
   output logic             fq_rd,
   output logic             fq_wr,
   output logic [15:0]      fq_ptr_dout,
   input  logic             alloc_req,
   input  logic [CNT_W-1:0] alloc_cnt,
   output logic             alloc_ack,
   output logic [PTR_W-1:0] alloc_ptr,
   input  logic             rel_req,
   input  logic [PTR_W-1:0] rel_ptr,
   output logic             rel_ack,
   output logic [PTR_W-1:0] inuse_count,
   output logic             err_underflow,
   output logic [15:0]      stall_cnt
);

   localparam int              IDX_W       = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] C_INUSE_MAX = PTR_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      A_WAIT = 2'd1,
      R_RD   = 2'd2,
      R_UPD  = 2'd3
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_refcnt [DEPTH];
   logic [PTR_W-1:0] r_lat_ptr;
   logic [CNT_W-1:0] r_rd_cnt;
   logic [IDX_W-1:0] w_alloc_idx;
   logic [IDX_W-1:0] w_rel_idx;

   assign w_alloc_idx = fq_ptr_din[IDX_W-1:0];
   assign w_rel_idx   = r_lat_ptr[IDX_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         fq_rd         <= 1'b0;
         fq_wr         <= 1'b0;
         fq_ptr_dout   <= '0;
         alloc_ack     <= 1'b0;
         alloc_ptr     <= '0;
         rel_ack       <= 1'b0;
         inuse_count   <= '0;
         err_underflow <= 1'b0;
         r_lat_ptr     <= '0;
         r_rd_cnt      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_refcnt[i] <= '0;
         end
      end else begin
         fq_rd     <= 1'b0;
         fq_wr     <= 1'b0;
         alloc_ack <= 1'b0;
         rel_ack   <= 1'b0;
         case (r_state)
            IDLE: begin
               // Releases win: they refill the queue that allocations drain.
               if (rel_req) begin
                  r_lat_ptr <= rel_ptr;
                  r_state   <= R_RD;
               end else if (alloc_req && fq_act && !fq_empty) begin
                  alloc_ptr             <= fq_ptr_din;
                  alloc_ack             <= 1'b1;
                  fq_rd                 <= 1'b1;
                  r_refcnt[w_alloc_idx] <= (alloc_cnt == '0) ? CNT_W'(1) : alloc_cnt;
                  if (inuse_count != C_INUSE_MAX) begin
                     inuse_count <= inuse_count + 1'b1;
                  end
                  r_state <= A_WAIT;
               end
            end
            A_WAIT: begin
               r_state <= IDLE;
            end
            R_RD: begin
               r_rd_cnt <= r_refcnt[w_rel_idx];
               r_state  <= R_UPD;
            end
            R_UPD: begin
               rel_ack <= 1'b1;
               if (r_rd_cnt == '0) begin
                  err_underflow <= 1'b1;
               end else if (r_rd_cnt == CNT_W'(1)) begin
                  r_refcnt[w_rel_idx] <= '0;
                  fq_wr               <= 1'b1;
                  fq_ptr_dout         <= {{(16-PTR_W){1'b0}}, r_lat_ptr};
                  if (inuse_count != '0) begin
                     inuse_count <= inuse_count - 1'b1;
                  end
               end else begin
                  r_refcnt[w_rel_idx] <= r_rd_cnt - 1'b1;
               end
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef PTR_ALLOC_STAT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if ((r_state == IDLE) && alloc_req && (fq_empty || !fq_act)
                   && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`else
   assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ptr_alloc_mgr.sv
`default_nettype none
// ============================================================================
// Module  : tb_ptr_alloc_mgr
// Brief   : Directed + random bench for ptr_alloc_mgr with a free-queue and
//           refcount reference model.
// Revision: 1.0
// ============================================================================
module tb_ptr_alloc_mgr;
   localparam int PTR_W = 10;
   localparam int DEPTH = 512;
   localparam int CNT_W = 4;
`ifdef PTR_ALLOC_STAT_EN
   localparam bit STAT = 1'b1;
`else
   localparam bit STAT = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [PTR_W-1:0] fq_ptr_din;
   logic             fq_empty, fq_act, fq_rd, fq_wr;
   logic [15:0]      fq_ptr_dout;
   logic             alloc_req, alloc_ack;
   logic [CNT_W-1:0] alloc_cnt;
   logic [PTR_W-1:0] alloc_ptr;
   logic             rel_req, rel_ack;
   logic [PTR_W-1:0] rel_ptr;
   logic [PTR_W-1:0] inuse_count;
   logic             err_underflow;
   logic [15:0]      stall_cnt;

   ptr_alloc_mgr #(.PTR_W(PTR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .fq_ptr_din(fq_ptr_din), .fq_empty(fq_empty), .fq_act(fq_act),
      .fq_rd(fq_rd), .fq_wr(fq_wr), .fq_ptr_dout(fq_ptr_dout),
      .alloc_req(alloc_req), .alloc_cnt(alloc_cnt), .alloc_ack(alloc_ack),
      .alloc_ptr(alloc_ptr), .rel_req(rel_req), .rel_ptr(rel_ptr),
      .rel_ack(rel_ack), .inuse_count(inuse_count),
      .err_underflow(err_underflow), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int fq_q[$];
   bit hold_empty;
   int rd_seen, wr_seen, ack_seen, viol;
   int mdl_cnt [DEPTH];
   int mdl_inuse;
   bit mdl_err;
   int mdl_stall;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_fq();
      fq_empty   = hold_empty || (fq_q.size() == 0);
      fq_ptr_din = (fq_q.size() > 0) ? PTR_W'(fq_q[0]) : '0;
   endtask

   // One clock; the free-queue model reacts to the DUT's pop/push strobes.
   task automatic step();
      bit ok_rd;
      ok_rd = fq_act && !fq_empty;
      @(posedge clk); #1;
      if (fq_rd) begin
         rd_seen++;
         if (!ok_rd) viol++;
         if (fq_q.size() > 0) void'(fq_q.pop_front());
      end
      if (fq_wr) begin
         wr_seen++;
         fq_q.push_back(int'(fq_ptr_dout));
      end
      if (fq_rd && fq_wr) viol++;
      if (alloc_ack) ack_seen++;
      drive_fq();
   endtask

   function automatic int exp_stall();
      return STAT ? mdl_stall : 0;
   endfunction

   task automatic check_model(input string tag);
      check({tag, " inuse"}, inuse_count, mdl_inuse);
      check({tag, " err"}, err_underflow, mdl_err);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " strobes"}, {alloc_ack, fq_rd, fq_wr, rel_ack, err_underflow}, 0);
      check({tag, " alloc_ptr"}, alloc_ptr, 0);
      check({tag, " fq_ptr_dout"}, fq_ptr_dout, 0);
      check({tag, " inuse"}, inuse_count, 0);
      check({tag, " stall"}, stall_cnt, 0);
   endtask

   task automatic do_alloc(input int cnt, input string tag);
      int exp_ptr, rd0, lat;
      bit got;
      exp_ptr   = fq_q[0];
      rd0       = rd_seen;
      alloc_cnt = CNT_W'(cnt);
      alloc_req = 1'b1;
      got = 0; lat = 0;
      while (!got && lat < 12) begin
         step(); lat++;
         if (alloc_ack) got = 1;
      end
      alloc_req = 1'b0;
      check({tag, " grant"}, got, 1);
      check({tag, " latency"}, lat, 1);
      check({tag, " ptr"}, alloc_ptr, exp_ptr);
      check({tag, " pop"}, rd_seen - rd0, 1);
      mdl_cnt[exp_ptr] = (cnt == 0) ? 1 : cnt;
      if (mdl_inuse < DEPTH) mdl_inuse++;
      check_model(tag);
      step();
   endtask

   task automatic do_release(input int ptr, input string tag);
      int c, wr0, lat, exp_wr;
      bit got;
      c = mdl_cnt[ptr];
      wr0 = wr_seen;
      rel_ptr = PTR_W'(ptr);
      rel_req = 1'b1;
      got = 0; lat = 0;
      while (!got && lat < 12) begin
         step(); lat++;
         if (rel_ack) got = 1;
      end
      rel_req = 1'b0;
      exp_wr = 0;
      if (c == 0) mdl_err = 1'b1;
      else if (c == 1) begin
         mdl_cnt[ptr] = 0;
         if (mdl_inuse > 0) mdl_inuse--;
         exp_wr = 1;
      end else mdl_cnt[ptr] = c - 1;
      check({tag, " rel_ack"}, got, 1);
      check({tag, " rel latency"}, lat, 3);
      check({tag, " fq_wr"}, fq_wr, exp_wr);
      if (exp_wr == 1) check({tag, " fq_ptr_dout"}, fq_ptr_dout, ptr);
      check_model(tag);
      step();
      check({tag, " push count"}, wr_seen - wr0, exp_wr);
   endtask

   initial begin
      int ack_r, ack_a, st, exp_a, p, ack0, rd0, wr0;
      int b2b[$];
      int exp3[3];
      int live[$];
      rst = 1'b1; fq_act = 1'b0; alloc_req = 1'b0; alloc_cnt = '0;
      rel_req = 1'b0; rel_ptr = '0; hold_empty = 1'b0;
      rd_seen = 0; wr_seen = 0; ack_seen = 0; viol = 0;
      mdl_inuse = 0; mdl_err = 1'b0; mdl_stall = 0;
      foreach (mdl_cnt[i]) mdl_cnt[i] = 0;
      fq_q = {0, 5};
      for (int i = 16; i < 80; i++) fq_q.push_back(i);
      drive_fq();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_zero("reset");

      // Queue not yet initialised: requests must be ignored.
      alloc_req = 1'b1; alloc_cnt = CNT_W'(1);
      repeat (4) step();
      mdl_stall += 4;
      check("init no pop", rd_seen, 0);
      check("init no ack", ack_seen, 0);
      check("init stall", stall_cnt, exp_stall());
      fq_act = 1'b1; drive_fq();
      do_alloc(1, "init");

      do_alloc(3, "mcast alloc");
      do_release(5, "mcast rel1");
      do_release(5, "mcast rel2");
      do_release(5, "mcast rel3");

      do_alloc(0, "zero alloc");
      do_release(16, "zero rel");

      do_release(16'h1FF, "underflow");
      check("underflow sticky", err_underflow, 1);

      // Release and allocate requested together.
      exp_a = fq_q[0];
      rel_ptr = PTR_W'(0); rel_req = 1'b1;
      alloc_cnt = CNT_W'(2); alloc_req = 1'b1;
      ack_r = 0; ack_a = 0; st = 0;
      while (ack_a == 0 && st < 12) begin
         step(); st++;
         if (rel_ack) begin ack_r = st; rel_req = 1'b0; end
         if (alloc_ack) begin ack_a = st; alloc_req = 1'b0; end
      end
      alloc_req = 1'b0; rel_req = 1'b0;
      check("arb rel step", ack_r, 3);
      check("arb alloc step", ack_a, 4);
      check("arb alloc ptr", alloc_ptr, exp_a);
      mdl_cnt[0] = 0; mdl_cnt[exp_a] = 2;
      check_model("arb");
      step();

      // Back-to-back grants.
      for (int i = 0; i < 3; i++) exp3[i] = fq_q[i];
      alloc_cnt = CNT_W'(1); alloc_req = 1'b1; st = 0;
      while (b2b.size() < 3 && st < 16) begin
         step(); st++;
         if (alloc_ack) begin
            check("b2b ptr", alloc_ptr, exp3[b2b.size()]);
            b2b.push_back(st);
         end
      end
      alloc_req = 1'b0;
      check("b2b grants", b2b.size(), 3);
      if (b2b.size() == 3) begin
         check("b2b gap1", b2b[1] - b2b[0], 2);
         check("b2b gap2", b2b[2] - b2b[1], 2);
      end
      for (int i = 0; i < 3; i++) begin
         mdl_cnt[exp3[i]] = 1;
         mdl_inuse++;
      end
      check_model("b2b");
      step();

      repeat (40) begin
         live.delete();
         foreach (mdl_cnt[i]) if (mdl_cnt[i] > 0) live.push_back(i);
         if (($urandom_range(0, 1) == 0 && live.size() > 0) || fq_q.size() < 2)
            do_release(live[$urandom_range(0, live.size() - 1)], "rand rel");
         else
            do_alloc(int'($urandom_range(0, 15)), "rand alloc");
      end

      // Empty queue: no grants, stalls counted when enabled.
      ack0 = ack_seen; rd0 = rd_seen;
      hold_empty = 1'b1; drive_fq();
      alloc_req = 1'b1;
      repeat (10) step();
      alloc_req = 1'b0; hold_empty = 1'b0; drive_fq();
      mdl_stall += 10;
      check("empty no ack", ack_seen - ack0, 0);
      check("empty no pop", rd_seen - rd0, 0);
      check("empty stall", stall_cnt, exp_stall());

      // Asynchronous reset while a last-reference release sits in R_UPD.
      p = fq_q[0];
      do_alloc(1, "pre-reset");
      rel_ptr = PTR_W'(p); rel_req = 1'b1;
      step(); step();
      #2 rst = 1'b1;
      #1 check_zero("mid reset");
      wr0 = wr_seen;
      rel_req = 1'b0;
      step(); step();
      check("mid reset no push", wr_seen - wr0, 0);
      rst = 1'b0;
      foreach (mdl_cnt[i]) mdl_cnt[i] = 0;
      mdl_inuse = 0; mdl_err = 1'b0; mdl_stall = 0;
      check_zero("post reset");
      do_alloc(2, "post reset alloc");

      check("protocol violations", viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
